// File: rtl/psola_output_player_pkg.sv
// Shared types, default sizes and the output saturation helper for the PSOLA output player.
package psola_output_player_pkg;

    localparam int unsigned DefaultMaxExtended = 2200;
    localparam int unsigned DefaultOutWidth    = 16;

    typedef enum logic [1:0] {
        BankEmpty,
        BankFilling,
        BankReady,
        BankPlaying
    } bank_state_e;

    // Clamp a 32-bit signed sample into the signed range of a w-bit word (result kept 32-bit).
    function automatic logic signed [31:0] saturate(input logic signed [31:0] v,
                                                    input int unsigned w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = $signed((32'd1 << (w - 1)) - 32'd1);
        lo = -hi - 32'sd1;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/psola_output_player_if.sv
// Upstream write stream, audio tick and status outputs of the PSOLA output player.
interface psola_output_player_if #(
    parameter int unsigned MAX_EXTENDED = psola_output_player_pkg::DefaultMaxExtended,
    parameter int unsigned OUT_WIDTH    = psola_output_player_pkg::DefaultOutWidth
);
    logic signed [31:0]                   in_val;
    logic [$clog2(MAX_EXTENDED)-1:0]      in_addr;
    logic                                 in_valid;
    logic                                 in_done;
    logic                                 sample_tick;
    logic                                 clear_flags;
    logic signed [OUT_WIDTH-1:0]          sample_out;
    logic                                 sample_valid;
    logic                                 bank_free;
    logic                                 underrun;
    logic                                 overflow;

    modport master (
        output in_val, in_addr, in_valid, in_done, sample_tick, clear_flags,
        input  sample_out, sample_valid, bank_free, underrun, overflow
    );

    modport slave (
        input  in_val, in_addr, in_valid, in_done, sample_tick, clear_flags,
        output sample_out, sample_valid, bank_free, underrun, overflow
    );

endinterface

// File: rtl/xilinx_true_dual_port_read_first_1_clock_ram.sv
// Single-clock true dual-port read-first block RAM with optional output register per port.
module xilinx_true_dual_port_read_first_1_clock_ram #(
    parameter int unsigned RAM_WIDTH       = 32,
    parameter int unsigned RAM_DEPTH       = 4400,
    parameter string       RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
    input  logic [$clog2(RAM_DEPTH)-1:0] addra,
    input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
    input  logic [RAM_WIDTH-1:0]         dina,
    input  logic [RAM_WIDTH-1:0]         dinb,
    input  logic                         clka,
    input  logic                         wea,
    input  logic                         web,
    input  logic                         ena,
    input  logic                         enb,
    input  logic                         rsta,
    input  logic                         rstb,
    input  logic                         regcea,
    input  logic                         regceb,
    output logic [RAM_WIDTH-1:0]         douta,
    output logic [RAM_WIDTH-1:0]         doutb
);
    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] ram_data_a;
    logic [RAM_WIDTH-1:0] ram_data_b;

    always_ff @(posedge clka) begin
        if (ena) begin
            if (wea) mem[addra] <= dina;
            ram_data_a <= mem[addra];
        end
        if (enb) begin
            if (web) mem[addrb] <= dinb;
            ram_data_b <= mem[addrb];
        end
    end

    if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_low_latency
        assign douta = ram_data_a;
        assign doutb = ram_data_b;
    end else begin : g_high_performance
        always_ff @(posedge clka) begin
            if (rsta) begin
                douta <= '0;
            end else if (regcea) begin
                douta <= ram_data_a;
            end
            if (rstb) begin
                doutb <= '0;
            end else if (regceb) begin
                doutb <= ram_data_b;
            end
        end
    end

endmodule

// File: rtl/psola_output_player.sv
// Double-banked PSOLA window buffer: upstream fills one bank while the audio tick drains the other,
// with a fixed 3-cycle tick-to-sample latency and sticky underrun/overflow flags.
module psola_output_player
    import psola_output_player_pkg::*;
#(
    parameter int unsigned MAX_EXTENDED = DefaultMaxExtended,
    parameter int unsigned OUT_WIDTH    = DefaultOutWidth
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    psola_output_player_if.slave  bus
);
    localparam int unsigned AddrW    = $clog2(MAX_EXTENDED);
    localparam int unsigned LenW     = $clog2(MAX_EXTENDED + 1);
    localparam int unsigned RamAddrW = $clog2(2 * MAX_EXTENDED);

    bank_state_e                  state_q [2];
    bank_state_e                  state_d [2];
    logic [LenW-1:0]              len_q [2];
    logic [LenW-1:0]              len_d [2];
    logic                         wr_bank_q, wr_bank_d;
    logic                         rd_bank_q, rd_bank_d;
    logic [AddrW-1:0]             rd_ptr_q, rd_ptr_d;
    logic                         discard_q, discard_d;
    logic                         done_q;
    logic [1:0]                   holdoff_q, holdoff_d;
    logic                         underrun_q, underrun_d;
    logic                         overflow_q, overflow_d;
    logic                         acc0_q, zero0_q, acc1_q, zero1_q;
    logic signed [OUT_WIDTH-1:0]  sample_q, sample_d;
    logic                         sample_valid_q;

    logic                         wr_en, rd_en, accept, rd_zero;
    logic [LenW-1:0]              addr_len;
    logic [RamAddrW-1:0]          wr_addr, rd_addr;
    logic [31:0]                  ram_doutb;
    logic [31:0]                  unused_douta;

    assign wr_addr = (wr_bank_q ? RamAddrW'(MAX_EXTENDED) : '0) + RamAddrW'(bus.in_addr);
    assign rd_addr = (rd_bank_q ? RamAddrW'(MAX_EXTENDED) : '0) + RamAddrW'(rd_ptr_q);
    assign addr_len = LenW'(bus.in_addr) + LenW'(1);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        rd_ptr_d   = rd_ptr_q;
        discard_d  = discard_q;
        holdoff_d  = (holdoff_q == 2'd0) ? 2'd0 : holdoff_q - 2'd1;
        underrun_d = underrun_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        rd_zero    = 1'b0;
        accept     = bus.sample_tick && (holdoff_q == 2'd0);

        // Write side only ever touches an EMPTY/FILLING bank; the read side only a READY/PLAYING
        // one, so both may update state_d in the same cycle without conflict.
        if (bus.in_valid) begin
            if (!discard_q && (state_q[wr_bank_q] == BankEmpty ||
                               state_q[wr_bank_q] == BankFilling)) begin
                wr_en              = 1'b1;
                state_d[wr_bank_q] = BankFilling;
                if (addr_len > len_q[wr_bank_q]) len_d[wr_bank_q] = addr_len;
            end else begin
                if (!discard_q) overflow_d = 1'b1;
                discard_d = 1'b1;
            end
        end

        if (bus.in_done && !done_q) begin
            discard_d = 1'b0;
            if (!discard_q && state_d[wr_bank_q] == BankFilling) begin
                state_d[wr_bank_q] = BankReady;
                wr_bank_d          = ~wr_bank_q;
            end
        end

        if (accept) begin
            holdoff_d = 2'd3;
            if (state_q[rd_bank_q] == BankReady || state_q[rd_bank_q] == BankPlaying) begin
                rd_en = 1'b1;
                if (LenW'(rd_ptr_q) + LenW'(1) == len_q[rd_bank_q]) begin
                    state_d[rd_bank_q] = BankEmpty;
                    len_d[rd_bank_q]   = '0;
                    rd_ptr_d           = '0;
                    rd_bank_d          = ~rd_bank_q;
                end else begin
                    state_d[rd_bank_q] = BankPlaying;
                    rd_ptr_d           = rd_ptr_q + AddrW'(1);
                end
            end else begin
                rd_zero    = 1'b1;
                underrun_d = 1'b1;
            end
        end

        if (bus.clear_flags) begin
            underrun_d = 1'b0;
            overflow_d = 1'b0;
        end

        sample_d = sample_q;
        if (acc1_q) begin
            sample_d = zero1_q ? '0 : OUT_WIDTH'(saturate($signed(ram_doutb), OUT_WIDTH));
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q[0]     <= BankEmpty;
            state_q[1]     <= BankEmpty;
            len_q[0]       <= '0;
            len_q[1]       <= '0;
            wr_bank_q      <= 1'b0;
            rd_bank_q      <= 1'b0;
            rd_ptr_q       <= '0;
            discard_q      <= 1'b0;
            // Starting high means an in_done already asserted at release is not an edge.
            done_q         <= 1'b1;
            holdoff_q      <= 2'd0;
            underrun_q     <= 1'b0;
            overflow_q     <= 1'b0;
            acc0_q         <= 1'b0;
            zero0_q        <= 1'b0;
            acc1_q         <= 1'b0;
            zero1_q        <= 1'b0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            wr_bank_q      <= wr_bank_d;
            rd_bank_q      <= rd_bank_d;
            rd_ptr_q       <= rd_ptr_d;
            discard_q      <= discard_d;
            done_q         <= bus.in_done;
            holdoff_q      <= holdoff_d;
            underrun_q     <= underrun_d;
            overflow_q     <= overflow_d;
            acc0_q         <= accept;
            zero0_q        <= rd_zero;
            acc1_q         <= acc0_q;
            zero1_q        <= zero0_q;
            sample_q       <= sample_d;
            sample_valid_q <= acc1_q;
        end
    end

    xilinx_true_dual_port_read_first_1_clock_ram #(
        .RAM_WIDTH       (32),
        .RAM_DEPTH       (2 * MAX_EXTENDED),
        .RAM_PERFORMANCE ("HIGH_PERFORMANCE")
    ) u_ram (
        .addra  (wr_addr),
        .addrb  (rd_addr),
        .dina   (bus.in_val),
        .dinb   (32'd0),
        .clka   (clk_in),
        .wea    (wr_en),
        .web    (1'b0),
        .ena    (1'b1),
        .enb    (rd_en),
        .rsta   (1'b0),
        .rstb   (1'b0),
        .regcea (1'b0),
        .regceb (acc0_q),
        .douta  (unused_douta),
        .doutb  (ram_doutb)
    );

    assign bus.sample_out   = sample_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.bank_free    = (state_q[0] == BankEmpty) || (state_q[1] == BankEmpty);
    assign bus.underrun     = underrun_q;
    assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_psola_output_player.sv
// Directed bench for psola_output_player: bank fill/commit, playback latency, saturation, flags.
module tb_psola_output_player;
    localparam int unsigned MaxExt = 2200;
    localparam int unsigned OutW   = 16;
    localparam int unsigned AW     = $clog2(MaxExt);

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    psola_output_player_if #(.MAX_EXTENDED(MaxExt), .OUT_WIDTH(OutW)) bus ();

    psola_output_player #(.MAX_EXTENDED(MaxExt), .OUT_WIDTH(OutW)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on a falling edge four cycles later.
    task automatic tick_expect(input logic [15:0] exp, input string tag);
        bus.sample_tick = 1'b1;
        @(negedge clk);
        bus.sample_tick = 1'b0;
        @(negedge clk);
        check({tag, ".early"}, 32'(bus.sample_valid), 32'd0);
        @(negedge clk);
        check({tag, ".valid"}, 32'(bus.sample_valid), 32'd1);
        check({tag, ".data"}, 32'($unsigned(bus.sample_out)), 32'(exp));
        @(negedge clk);
        check({tag, ".width"}, 32'(bus.sample_valid), 32'd0);
    endtask

    task automatic write_sample(input int addr, input logic [31:0] val);
        bus.in_valid = 1'b1;
        bus.in_addr  = AW'(addr);
        bus.in_val   = val;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic write_ramp(input int n, input int start);
        for (int i = 0; i < n; i++) write_sample(i, 32'(start + i));
    endtask

    task automatic commit();
        bus.in_done = 1'b1;
        @(negedge clk);
        bus.in_done = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n           = 1'b1;
        bus.in_val      = '0;
        bus.in_addr     = '0;
        bus.in_valid    = 1'b0;
        bus.in_done     = 1'b0;
        bus.sample_tick = 1'b0;
        bus.clear_flags = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst.sample_out", 32'($unsigned(bus.sample_out)), 32'd0);
        check("rst.sample_valid", 32'(bus.sample_valid), 32'd0);
        check("rst.bank_free", 32'(bus.bank_free), 32'd1);
        check("rst.underrun", 32'(bus.underrun), 32'd0);
        check("rst.overflow", 32'(bus.overflow), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic window of ten samples into bank 0
        write_ramp(10, 1);
        commit();
        check("basic.bank_free", 32'(bus.bank_free), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick_expect(16'(i + 1), $sformatf("basic[%0d]", i));
            check($sformatf("basic[%0d].bank_free", i), 32'(bus.bank_free), 32'd1);
        end
        check("basic.underrun", 32'(bus.underrun), 32'd0);

        // Saturation into bank 1
        write_sample(0, 32'h0001_2345);
        write_sample(1, 32'hFFFF_0000);
        write_sample(2, 32'hFFFF_FFFB);
        commit();
        tick_expect(16'h7FFF, "sat.pos");
        tick_expect(16'h8000, "sat.neg");
        tick_expect(16'hFFFB, "sat.pass");

        // Short window then underrun
        write_ramp(4, 100);
        commit();
        for (int i = 0; i < 4; i++) tick_expect(16'(100 + i), $sformatf("short[%0d]", i));
        check("short.underrun_pre", 32'(bus.underrun), 32'd0);
        tick_expect(16'd0, "under[0]");
        check("under.flag", 32'(bus.underrun), 32'd1);
        tick_expect(16'd0, "under[1]");
        bus.clear_flags = 1'b1;
        @(negedge clk);
        bus.clear_flags = 1'b0;
        @(negedge clk);
        check("under.cleared", 32'(bus.underrun), 32'd0);

        // Overflow: two committed windows, third dropped, later window accepted
        write_ramp(3, 200);
        commit();
        write_ramp(2, 300);
        commit();
        check("ovf.bank_free_full", 32'(bus.bank_free), 32'd0);
        check("ovf.flag_pre", 32'(bus.overflow), 32'd0);
        write_ramp(2, 400);
        check("ovf.flag", 32'(bus.overflow), 32'd1);
        commit();
        check("ovf.bank_free_still", 32'(bus.bank_free), 32'd0);
        for (int i = 0; i < 3; i++) tick_expect(16'(200 + i), $sformatf("ovf.a[%0d]", i));
        check("ovf.bank_free_drained", 32'(bus.bank_free), 32'd1);
        write_ramp(2, 500);
        commit();
        for (int i = 0; i < 2; i++) tick_expect(16'(300 + i), $sformatf("ovf.b[%0d]", i));
        for (int i = 0; i < 2; i++) tick_expect(16'(500 + i), $sformatf("ovf.c[%0d]", i));
        bus.clear_flags = 1'b1;
        @(negedge clk);
        bus.clear_flags = 1'b0;
        @(negedge clk);
        check("ovf.cleared", 32'(bus.overflow), 32'd0);

        // Clear wins over a same-cycle underrun set
        bus.clear_flags = 1'b1;
        tick_expect(16'd0, "clrwin");
        bus.clear_flags = 1'b0;
        check("clrwin.underrun", 32'(bus.underrun), 32'd0);

        // Last read of bank 0 coincides with commit of bank 1
        write_ramp(2, 600);
        commit();
        write_ramp(3, 700);
        tick_expect(16'd600, "swap[0]");
        bus.sample_tick = 1'b1;
        bus.in_done     = 1'b1;
        @(negedge clk);
        bus.sample_tick = 1'b0;
        bus.in_done     = 1'b0;
        @(negedge clk);
        check("swap[1].early", 32'(bus.sample_valid), 32'd0);
        @(negedge clk);
        check("swap[1].valid", 32'(bus.sample_valid), 32'd1);
        check("swap[1].data", 32'($unsigned(bus.sample_out)), 32'd601);
        @(negedge clk);
        check("swap.bank_free", 32'(bus.bank_free), 32'd1);
        for (int i = 0; i < 3; i++) tick_expect(16'(700 + i), $sformatf("swap.b1[%0d]", i));
        check("swap.underrun", 32'(bus.underrun), 32'd0);
        check("swap.overflow", 32'(bus.overflow), 32'd0);

        // Reset in the middle of playback with a read in flight
        write_ramp(10, 1);
        commit();
        write_sample(0, 32'd99);
        commit();
        check("mrst.bank_free_pre", 32'(bus.bank_free), 32'd0);
        for (int i = 0; i < 4; i++) tick_expect(16'(i + 1), $sformatf("mrst[%0d]", i));
        bus.sample_tick = 1'b1;
        @(negedge clk);
        bus.sample_tick = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst.sample_out", 32'($unsigned(bus.sample_out)), 32'd0);
        check("mrst.sample_valid", 32'(bus.sample_valid), 32'd0);
        check("mrst.bank_free", 32'(bus.bank_free), 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("mrst.valid_held", 32'(bus.sample_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        tick_expect(16'd0, "mrst.after");
        check("mrst.underrun", 32'(bus.underrun), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
